axi_lite_mem_master: RTL

Bridges a simple in-order memory request port (BRAM-style enable/strobe/address/data with valid/ready) to an AXI-lite master port, the initiator counterpart of our AXI-lite-to-BRAM controller. It lets cores, DMA engines and test drivers reach any AXI-lite slave. Up to MAX_OUTSTANDING transactions can be in flight. Responses return strictly in request order, even when reads and writes are mixed.

---
 rtl/axi_lite_mem_master_if.sv | 38 +++
 rtl/axi_lite_mem_master.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_master_if.sv
// AXI-lite channel bundle shared by initiators and targets.
// A transfer on any channel happens in the cycle where valid and ready are both high.
interface axi_lite_channel #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) ();
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;

  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_mem_master.sv
// In-order memory request port to AXI-lite initiator bridge with up to
// MAX_OUTSTANDING transactions in flight and responses returned in request order.
module axi_lite_mem_master #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_WIDTH/8-1:0] req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  axi_lite_channel.master         master
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [1:0]       RESP_OKAY = 2'b00;

  if (master.DATA_WIDTH != DATA_WIDTH) begin : g_bad_data_width
    $fatal(1, "axi_lite_mem_master: DATA_WIDTH differs from interface DATA_WIDTH");
  end
  if (master.ADDR_WIDTH != ADDR_WIDTH) begin : g_bad_addr_width
    $fatal(1, "axi_lite_mem_master: ADDR_WIDTH differs from interface ADDR_WIDTH");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_max
    $fatal(1, "axi_lite_mem_master: MAX_OUTSTANDING must be at least 1");
  end

  logic                    aw_valid_q;
  logic                    w_valid_q;
  logic                    ar_valid_q;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        fifo_cnt_q;
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic                    order_mem [2**PTR_W];
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

  logic is_write;
  logic room;
  logic aw_free;
  logic w_free;
  logic ar_free;
  logic accept;
  logic head_write;
  logic fifo_empty;
  logic slot_free;
  logic b_hs;
  logic r_hs;
  logic pop;
  logic rsp_hs;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A holding register is free when empty or when its content transfers this cycle.
  assign is_write  = |req_we;
  assign room      = cnt_q < CNT_MAX;
  assign aw_free   = !aw_valid_q || master.aw_ready;
  assign w_free    = !w_valid_q || master.w_ready;
  assign ar_free   = !ar_valid_q || master.ar_ready;
  assign req_ready = room && (is_write ? (aw_free && w_free) : ar_free);
  assign accept    = req_valid && req_ready;

  assign fifo_empty     = (fifo_cnt_q == '0);
  assign head_write     = order_mem[rd_ptr_q];
  assign slot_free      = !rsp_valid_q || rsp_ready;
  assign master.b_ready = !fifo_empty && head_write && slot_free;
  assign master.r_ready = !fifo_empty && !head_write && slot_free;
  assign b_hs           = master.b_valid && master.b_ready;
  assign r_hs           = master.r_valid && master.r_ready;
  assign pop            = b_hs || r_hs;
  assign rsp_hs         = rsp_valid_q && rsp_ready;

  assign master.aw_valid = aw_valid_q;
  assign master.aw_addr  = aw_addr_q;
  assign master.aw_prot  = 3'b000;
  assign master.w_valid  = w_valid_q;
  assign master.w_data   = w_data_q;
  assign master.w_strb   = w_strb_q;
  assign master.ar_valid = ar_valid_q;
  assign master.ar_addr  = ar_addr_q;
  assign master.ar_prot  = 3'b000;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      cnt_q       <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (accept && is_write)    aw_valid_q <= 1'b1;
      else if (master.aw_ready)  aw_valid_q <= 1'b0;
      if (accept && is_write)    w_valid_q  <= 1'b1;
      else if (master.w_ready)   w_valid_q  <= 1'b0;
      if (accept && !is_write)   ar_valid_q <= 1'b1;
      else if (master.ar_ready)  ar_valid_q <= 1'b0;

      // cnt covers everything from acceptance until the response leaves the bridge
      case ({accept, rsp_hs})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      case ({accept, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (accept) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);

      if (pop)         rsp_valid_q <= 1'b1;
      else if (rsp_hs) rsp_valid_q <= 1'b0;
    end
  end

  // Payload registers carry no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    if (accept && is_write) begin
      aw_addr_q <= req_addr;
      w_data_q  <= req_wdata;
      w_strb_q  <= req_we;
    end
    if (accept && !is_write) ar_addr_q <= req_addr;
    if (accept) order_mem[wr_ptr_q] <= is_write;
    if (b_hs) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= (master.b_resp != RESP_OKAY);
    end else if (r_hs) begin
      rsp_rdata_q <= master.r_data;
      rsp_err_q   <= (master.r_resp != RESP_OKAY);
    end
  end
endmodule
